hdcp_seq_ctl: RTL and testbench
===============================

# hdcp_seq_ctl

Parametrised HDCP 1.4 cipher sequencer for the overlay receive path. It sniffs the authentication trigger, then drives an external `hdcp_cipher` instance through authentication, per-frame re-init and per-line rekey. Compared with the single-mode sequencer, it adds:
- runtime OESS/EESS selection;
- a frame counter with an Ri-update strobe;
- a configurable rekey lead;
- a handshake timeout with error recovery.

## Interface
- `FRAME_CNT_W`, 7: frame counter width; `ri_update` fires every 2^FRAME_CNT_W frame keys.
- `REKEY_LAT`, 2: cycles from qualified `line_end` to `cipher_rekey` pulse (1..4).
- `TIMEOUT`, 4096: max cycles allowed for a cipher handshake.
- `TO_W`, 13: timeout counter width (≥ clog2(TIMEOUT+1)).

Ports:
- `clk` in 1: pixel clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `hpd` in 1: high = no cable; forces UNPLUG.
- `aksv_write` in 1: one-cycle strobe, AKsv byte 14 written.
- `eess` in 1: 1 = EESS, 0 = OESS; sampled each vsync rising edge.
- `de` in 1: video data enable.
- `vsync` in 1: positive-active vertical sync.
- `line_end` in 1: end-of-active-line marker.
- `adv` in 1: cipher advance request (de | data island).
- `ctl_code` in 4: decoded CTL3..0.
- `cipher_ready` in 1: `stream_ready` from the cipher.
- `cipher_init` out 1: `hdcpBlockCipher_init` pulse.
- `cipher_auth` out 1: authentication qualifier; high with init only.
- `cipher_rekey` out 1: `hdcpRekeyCipher` pulse.
- `cipher_stream_ena` out 1: `hdcpStreamCipher`.
- `enc_active` out 1: current frame is encrypted.
- `ri_update` out 1: one-cycle Ri strobe.
- `frame_cnt` out FRAME_CNT_W: frame keys since auth.
- `timeout_err` out 1: sticky handshake-timeout flag.
- `state` out 4: encoded state, for CSR readback.

## Operation
States: UNPLUG, WAIT_AKSV, AUTH_PULSE, AUTH_WAIT, FRAME_PULSE, FRAME_WAIT, WAIT_ENC, READY, REKEY_WAIT, ERROR.

Transition priority:
- `rst` beats `hpd`, which beats `aksv_write`, which beats the normal transitions.
- `hpd` forces UNPLUG.
- `aksv_write` in any state other than UNPLUG forces AUTH_PULSE (re-authentication restart).

Transitions:
- UNPLUG → WAIT_AKSV when `!hpd`.
- WAIT_AKSV → AUTH_PULSE on `aksv_write`.
- AUTH_PULSE: `cipher_init`=`cipher_auth`=1 for one cycle; clears `frame_cnt`, `enc_active`, `timeout_err`. Next state AUTH_WAIT.
- Handshake wait rule (applies to AUTH_WAIT, FRAME_WAIT, REKEY_WAIT):
  - a `seen_low` flag sets when `cipher_ready`=0;
  - exit requires `seen_low & cipher_ready`;
  - the timeout counter loads 0 on entry; reaching TIMEOUT → ERROR and sets `timeout_err`.
- AUTH_WAIT exit → FRAME_PULSE (post-auth frame key, no vsync needed).
- FRAME_PULSE: `cipher_init`=1, `cipher_auth`=0, one cycle → FRAME_WAIT.
- FRAME_WAIT exit → WAIT_ENC. `frame_cnt` increments on exit, except the first exit after AUTH. Wrapping from 2^W−1 to 0 pulses `ri_update`.
- WAIT_ENC:
  - while `vsync`: `ctl_code`=1001 sets `enc_active`; 0001 clears it (EESS).
  - in OESS, `enc_active` takes the `adv`-independent constant 1.
  - on vsync low → READY.
- READY:
  - `cipher_stream_ena` = `enc_active & adv`;
  - `line_end & de` launches the rekey delay line;
  - `cipher_ready`=0 → REKEY_WAIT;
  - else vsync rising → FRAME_PULSE.
- REKEY_WAIT exit → READY.
- ERROR: all cipher outputs 0; holds until `aksv_write` or `hpd`.
- `cipher_stream_ena` is 0 in every state except READY.

## Timing
- Reset / hpd values: state UNPLUG; every output 0; `frame_cnt` 0; delay line cleared.
- Control outputs are registered: one cycle after the state is entered.
- `cipher_rekey` is asserted exactly REKEY_LAT cycles after the `line_end & de` sample, with no further gating. An `aksv_write` arriving mid-pipeline flushes the delay line.
- vsync rising is detected with one register. A rise in the same cycle as a ready drop in READY goes to REKEY_WAIT; the frame key is then taken on the next vsync rising.
- An `aksv_write` coinciding with the `cipher_ready` rise resolves to AUTH_PULSE.
- A cipher whose ready never drops times out after TIMEOUT cycles.

## Structure
- `hdcp_seq_pkg` holds:
  - the state encoding localparams;
  - CTL codes ENC_EN=4'b1001, ENC_DIS=4'b0001;
  - the `state` output encoding, shared with the CSR map.
- Sub-module `hdcp_pulse_delay` (parameter LAT; inputs `clk`, `rst`, `flush`, `in`; output `out`) implements the rekey delay line.
- The cipher stays outside this block; the top level connects it.

## Test plan
- Reset, then `hpd`=0, then `aksv_write`, with a cipher model (ready low 3 cycles after init, 48 cycles busy) → state path through AUTH_WAIT, FRAME_WAIT, WAIT_ENC. Exactly one init with auth=1, then one with auth=0; `frame_cnt`=0.
- EESS: vsync with `ctl_code`=1001 → `enc_active`=1 and `cipher_stream_ena` follows `adv`. Next frame with 0001 → `enc_active`=0 and stream_ena stays 0.
- `line_end & de` in READY with REKEY_LAT=2 → `cipher_rekey` high exactly 2 cycles later; REKEY_WAIT entered, then READY is regained.
- FRAME_CNT_W=3 over 9 frames → `frame_cnt` wraps 7→0 with a single `ri_update` pulse at the wrap.
- Cipher model never drops ready, TIMEOUT=64 → ERROR after 64 cycles, `timeout_err`=1. A subsequent `aksv_write` clears it and restarts auth.
- `hpd` asserted mid-REKEY_WAIT while simultaneously strobing `aksv_write` → UNPLUG next cycle, all outputs 0.

Source files
------------

// File: rtl/hdcp_seq_ctl_pkg.sv
// hdcp_seq_pkg: shared definitions for the HDCP 1.4 cipher sequencer.
//   - state encoding (also the CSR readback encoding of the `state` port)
//   - decoded CTL3..0 codes that switch encryption in EESS mode
package hdcp_seq_pkg;

  // State encoding as seen by software through the CSR map.
  localparam logic [3:0] ST_UNPLUG      = 4'd0;
  localparam logic [3:0] ST_WAIT_AKSV   = 4'd1;
  localparam logic [3:0] ST_AUTH_PULSE  = 4'd2;
  localparam logic [3:0] ST_AUTH_WAIT   = 4'd3;
  localparam logic [3:0] ST_FRAME_PULSE = 4'd4;
  localparam logic [3:0] ST_FRAME_WAIT  = 4'd5;
  localparam logic [3:0] ST_WAIT_ENC    = 4'd6;
  localparam logic [3:0] ST_READY       = 4'd7;
  localparam logic [3:0] ST_REKEY_WAIT  = 4'd8;
  localparam logic [3:0] ST_ERROR       = 4'd9;

  typedef enum logic [3:0] {
    S_UNPLUG      = ST_UNPLUG,
    S_WAIT_AKSV   = ST_WAIT_AKSV,
    S_AUTH_PULSE  = ST_AUTH_PULSE,
    S_AUTH_WAIT   = ST_AUTH_WAIT,
    S_FRAME_PULSE = ST_FRAME_PULSE,
    S_FRAME_WAIT  = ST_FRAME_WAIT,
    S_WAIT_ENC    = ST_WAIT_ENC,
    S_READY       = ST_READY,
    S_REKEY_WAIT  = ST_REKEY_WAIT,
    S_ERROR       = ST_ERROR
  } seq_state_t;

  // CTL3..0 codes sampled during vsync in EESS mode.
  localparam logic [3:0] CTL_ENC_EN  = 4'b1001;
  localparam logic [3:0] CTL_ENC_DIS = 4'b0001;

endpackage

// File: rtl/hdcp_pulse_delay.sv
// hdcp_pulse_delay: fixed-latency delay line for single-cycle pulses.
// A pulse on `in` reappears on `out` exactly LAT cycles later; `flush`
// discards every pulse still in flight.
//   clk   - clock
//   rst   - synchronous active-high reset
//   flush - synchronous clear of the pipeline
//   in    - pulse to delay
//   out   - delayed pulse (registered)
module hdcp_pulse_delay #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in,
  output logic out
);

  logic [LAT-1:0] shift_r;

  // Shift register; the shift form also covers LAT == 1.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      shift_r <= {LAT{1'b0}};
    end else begin
      shift_r <= (shift_r << 1) | LAT'(in);
    end
  end

  assign out = shift_r[LAT-1];

endmodule

// File: rtl/hdcp_seq_ctl.sv
// hdcp_seq_ctl: HDCP 1.4 cipher sequencer for the overlay receive path.
// Detects the AKsv write that starts authentication and then walks an
// external hdcp_cipher through auth, per-frame re-init and per-line rekey.
// Inputs : clk, rst, hpd (high = no cable), aksv_write, eess (mode select),
//          de, vsync, line_end, adv, ctl_code[3:0], cipher_ready.
// Outputs: cipher_init, cipher_auth, cipher_rekey, cipher_stream_ena,
//          enc_active, ri_update, frame_cnt, timeout_err, state[3:0].
// All control outputs are registered and follow the state by one cycle.
module hdcp_seq_ctl
  import hdcp_seq_pkg::*;
#(
  parameter int FRAME_CNT_W = 7,
  parameter int REKEY_LAT   = 2,
  parameter int TIMEOUT     = 4096,
  parameter int TO_W        = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hpd,
  input  logic                   aksv_write,
  input  logic                   eess,
  input  logic                   de,
  input  logic                   vsync,
  input  logic                   line_end,
  input  logic                   adv,
  input  logic [3:0]             ctl_code,
  input  logic                   cipher_ready,
  output logic                   cipher_init,
  output logic                   cipher_auth,
  output logic                   cipher_rekey,
  output logic                   cipher_stream_ena,
  output logic                   enc_active,
  output logic                   ri_update,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   timeout_err,
  output logic [3:0]             state
);

  seq_state_t             state_r;
  logic                   vsync_d_r;
  logic                   eess_r;
  logic                   seen_low_r;
  logic                   first_frame_r;
  logic [TO_W-1:0]        to_cnt_r;
  logic [FRAME_CNT_W-1:0] frame_cnt_r;
  logic                   enc_active_r;
  logic                   init_r;
  logic                   auth_r;
  logic                   stream_r;
  logic                   ri_r;
  logic                   timeout_err_r;

  logic vsync_rise_s;
  logic eess_mode_s;
  logic hs_done_s;
  logic hs_expired_s;
  logic rekey_launch_s;
  logic flush_s;

  assign vsync_rise_s   = vsync & ~vsync_d_r;
  // A mode change presented with the vsync edge applies to that frame.
  assign eess_mode_s    = vsync_rise_s ? eess : eess_r;
  // The cipher must have shown busy before its ready counts as done.
  assign hs_done_s      = seen_low_r & cipher_ready;
  assign hs_expired_s   = (to_cnt_r == TO_W'(TIMEOUT - 1));
  assign rekey_launch_s = (state_r == S_READY) & line_end & de;
  assign flush_s        = aksv_write | hpd;

  // vsync edge detector and per-frame EESS/OESS mode capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d_r <= 1'b0;
      eess_r    <= 1'b0;
    end else begin
      vsync_d_r <= vsync;
      if (vsync_rise_s) begin
        eess_r <= eess;
      end
    end
  end

  // Sequencer FSM with its counters and registered cipher controls.
  always_ff @(posedge clk) begin
    if (rst || hpd) begin
      state_r       <= S_UNPLUG;
      seen_low_r    <= 1'b0;
      first_frame_r <= 1'b0;
      to_cnt_r      <= {TO_W{1'b0}};
      frame_cnt_r   <= {FRAME_CNT_W{1'b0}};
      enc_active_r  <= 1'b0;
      init_r        <= 1'b0;
      auth_r        <= 1'b0;
      stream_r      <= 1'b0;
      ri_r          <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      init_r     <= (state_r == S_AUTH_PULSE) || (state_r == S_FRAME_PULSE);
      auth_r     <= (state_r == S_AUTH_PULSE);
      stream_r   <= (state_r == S_READY) && enc_active_r && adv;
      ri_r       <= 1'b0;
      seen_low_r <= seen_low_r | ~cipher_ready;
      if (aksv_write && (state_r != S_UNPLUG)) begin
        // Re-authentication restart wins over any handshake in progress.
        state_r <= S_AUTH_PULSE;
      end else begin
        case (state_r)
          S_UNPLUG:    state_r <= S_WAIT_AKSV;
          S_WAIT_AKSV: state_r <= S_WAIT_AKSV;
          S_AUTH_PULSE: begin
            frame_cnt_r   <= {FRAME_CNT_W{1'b0}};
            enc_active_r  <= 1'b0;
            timeout_err_r <= 1'b0;
            first_frame_r <= 1'b1;
            to_cnt_r      <= {TO_W{1'b0}};
            seen_low_r    <= 1'b0;
            state_r       <= S_AUTH_WAIT;
          end
          S_AUTH_WAIT: begin
            if (hs_done_s) begin
              state_r <= S_FRAME_PULSE;
            end else if (hs_expired_s) begin
              state_r       <= S_ERROR;
              timeout_err_r <= 1'b1;
            end else begin
              to_cnt_r <= to_cnt_r + TO_W'(1);
            end
          end
          S_FRAME_PULSE: begin
            to_cnt_r   <= {TO_W{1'b0}};
            seen_low_r <= 1'b0;
            state_r    <= S_FRAME_WAIT;
          end
          S_FRAME_WAIT: begin
            if (hs_done_s) begin
              state_r <= S_WAIT_ENC;
              // The key taken straight after auth is frame 0, not a new frame.
              if (first_frame_r) begin
                first_frame_r <= 1'b0;
              end else begin
                frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
                ri_r        <= &frame_cnt_r;
              end
            end else if (hs_expired_s) begin
              state_r       <= S_ERROR;
              timeout_err_r <= 1'b1;
            end else begin
              to_cnt_r <= to_cnt_r + TO_W'(1);
            end
          end
          S_WAIT_ENC: begin
            if (vsync) begin
              if (!eess_mode_s) begin
                enc_active_r <= 1'b1;
              end else if (ctl_code == CTL_ENC_EN) begin
                enc_active_r <= 1'b1;
              end else if (ctl_code == CTL_ENC_DIS) begin
                enc_active_r <= 1'b0;
              end else begin
                enc_active_r <= enc_active_r;
              end
            end else begin
              state_r <= S_READY;
            end
          end
          S_READY: begin
            // A ready drop beats a simultaneous vsync rise; that frame key
            // is then deferred to the next vsync rise.
            if (!cipher_ready) begin
              to_cnt_r   <= {TO_W{1'b0}};
              seen_low_r <= 1'b1;
              state_r    <= S_REKEY_WAIT;
            end else if (vsync_rise_s) begin
              state_r <= S_FRAME_PULSE;
            end else begin
              state_r <= S_READY;
            end
          end
          S_REKEY_WAIT: begin
            if (hs_done_s) begin
              state_r <= S_READY;
            end else if (hs_expired_s) begin
              state_r       <= S_ERROR;
              timeout_err_r <= 1'b1;
            end else begin
              to_cnt_r <= to_cnt_r + TO_W'(1);
            end
          end
          S_ERROR: state_r <= S_ERROR;
          default: state_r <= S_UNPLUG;
        endcase
      end
    end
  end

  hdcp_pulse_delay #(
    .LAT (REKEY_LAT)
  ) u_rekey_dly (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_s),
    .in    (rekey_launch_s),
    .out   (cipher_rekey)
  );

  assign cipher_init       = init_r;
  assign cipher_auth       = auth_r;
  assign cipher_stream_ena = stream_r;
  assign enc_active        = enc_active_r;
  assign ri_update         = ri_r;
  assign frame_cnt         = frame_cnt_r;
  assign timeout_err       = timeout_err_r;
  assign state             = state_r;

endmodule

// File: tb/tb_hdcp_seq_ctl.sv
// Self-checking bench for hdcp_seq_ctl with a behavioural cipher model.
module tb_hdcp_seq_ctl;
  import hdcp_seq_pkg::*;

  localparam int FCW = 3;
  localparam int LAT = 2;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst, hpd, aksv_write, eess, de, vsync, line_end, adv;
  logic [3:0]     ctl_code;
  logic           cipher_ready;
  logic           cipher_init, cipher_auth, cipher_rekey, cipher_stream_ena;
  logic           enc_active, ri_update, timeout_err;
  logic [FCW-1:0] frame_cnt;
  logic [3:0]     state;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  hdcp_seq_ctl #(
    .FRAME_CNT_W (FCW),
    .REKEY_LAT   (LAT),
    .TIMEOUT     (TMO),
    .TO_W        (7)
  ) dut (
    .clk (clk), .rst (rst), .hpd (hpd), .aksv_write (aksv_write),
    .eess (eess), .de (de), .vsync (vsync), .line_end (line_end),
    .adv (adv), .ctl_code (ctl_code), .cipher_ready (cipher_ready),
    .cipher_init (cipher_init), .cipher_auth (cipher_auth),
    .cipher_rekey (cipher_rekey), .cipher_stream_ena (cipher_stream_ena),
    .enc_active (enc_active), .ri_update (ri_update),
    .frame_cnt (frame_cnt), .timeout_err (timeout_err), .state (state)
  );

  // Cipher model: busy (ready low) from 3 cycles after an init/rekey, for
  // 48 cycles. When stuck it ignores requests and never drops ready.
  int   cm_cnt = 0;
  logic cm_stuck = 1'b0;
  always @(posedge clk) begin
    if (rst) cm_cnt <= 0;
    else if ((cipher_init || cipher_rekey) && !cm_stuck) cm_cnt <= 1;
    else if (cm_cnt != 0 && cm_cnt < 51) cm_cnt <= cm_cnt + 1;
    else cm_cnt <= 0;
  end
  assign cipher_ready = !(cm_cnt >= 3 && cm_cnt < 51);

  // Pulse counters observed on the cipher-facing outputs.
  int n_init_auth = 0, n_init_frame = 0, n_ri = 0, n_auth_alone = 0;
  always @(posedge clk) begin
    if (cipher_init && cipher_auth) n_init_auth <= n_init_auth + 1;
    if (cipher_init && !cipher_auth) n_init_frame <= n_init_frame + 1;
    if (!cipher_init && cipher_auth) n_auth_alone <= n_auth_alone + 1;
    if (ri_update) n_ri <= n_ri + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, state=%0d", state);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] tgt, input int budget, input string tag);
    int k = 0;
    while (state !== tgt && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(state), 32'(tgt));
  endtask

  task automatic pulse_aksv();
    aksv_write = 1'b1;
    step();
    aksv_write = 1'b0;
  endtask

  // Runs one frame: vsync high with the given mode/code until the frame key
  // has been taken, then vsync low until READY.
  task automatic run_frame(input logic e, input logic [3:0] c, input string tag);
    eess = e;
    ctl_code = c;
    vsync = 1'b1;
    wait_state(ST_WAIT_ENC, 200, {tag, "_wait_enc"});
    repeat (3) step();
    vsync = 1'b0;
    ctl_code = 4'd0;
    wait_state(ST_READY, 10, {tag, "_ready"});
  endtask

  // Launches one line rekey and checks its exact latency.
  task automatic rekey_line(input string tag);
    de = 1'b1;
    line_end = 1'b1;
    step();
    de = 1'b0;
    line_end = 1'b0;
    check({tag, "_early"}, 32'(cipher_rekey), 32'd0);
    step();
    check({tag, "_at_lat"}, 32'(cipher_rekey), 32'd1);
    step();
    check({tag, "_after"}, 32'(cipher_rekey), 32'd0);
  endtask

  int       a0, f0, r0, cnt, exp_fc, exp_ri;
  logic     exp_enc, e, a;
  logic [3:0] c;

  initial begin
    rst = 1'b1; hpd = 1'b1; aksv_write = 1'b0; eess = 1'b0; de = 1'b0;
    vsync = 1'b0; line_end = 1'b0; adv = 1'b0; ctl_code = 4'd0;
    repeat (3) step();
    check("rst_state", 32'(state), 32'(ST_UNPLUG));
    check("rst_outs", 32'({cipher_init, cipher_auth, cipher_rekey, cipher_stream_ena,
                           enc_active, ri_update, timeout_err}), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    step();
    check("hpd_holds_unplug", 32'(state), 32'(ST_UNPLUG));
    hpd = 1'b0;
    step();
    check("plug_wait_aksv", 32'(state), 32'(ST_WAIT_AKSV));

    // Authentication, then the post-auth frame key.
    a0 = n_init_auth;
    f0 = n_init_frame;
    pulse_aksv();
    check("auth_pulse", 32'(state), 32'(ST_AUTH_PULSE));
    step();
    check("auth_wait", 32'(state), 32'(ST_AUTH_WAIT));
    check("auth_init_hi", 32'({cipher_init, cipher_auth}), 32'd3);
    step();
    check("auth_init_1cyc", 32'(cipher_init), 32'd0);
    wait_state(ST_FRAME_WAIT, 100, "auth_to_frame_wait");
    wait_state(ST_WAIT_ENC, 100, "auth_to_wait_enc");
    wait_state(ST_READY, 10, "auth_to_ready");
    step();
    check("auth_init_count", 32'(n_init_auth - a0), 32'd1);
    check("frame_init_count", 32'(n_init_frame - f0), 32'd1);
    check("auth_fcnt", 32'(frame_cnt), 32'd0);
    check("auth_enc", 32'(enc_active), 32'd0);
    exp_fc = 0;
    exp_ri = 0;

    // EESS enable frame: stream enable tracks adv one cycle later.
    run_frame(1'b1, CTL_ENC_EN, "eess_en");
    exp_fc = 1;
    check("eess_en_enc", 32'(enc_active), 32'd1);
    check("eess_en_fcnt", 32'(frame_cnt), 32'(exp_fc));
    for (int i = 0; i < 16; i++) begin
      a = 1'($urandom_range(0, 1));
      adv = a;
      step();
      check("stream_follows_adv", 32'(cipher_stream_ena), 32'(a));
    end
    adv = 1'b0;

    // EESS disable frame: stream stays off whatever adv does.
    run_frame(1'b1, CTL_ENC_DIS, "eess_dis");
    exp_fc = 2;
    check("eess_dis_enc", 32'(enc_active), 32'd0);
    for (int i = 0; i < 8; i++) begin
      adv = 1'($urandom_range(0, 1));
      step();
      check("stream_off", 32'(cipher_stream_ena), 32'd0);
    end
    adv = 1'b0;

    // Line rekeys with random spacing; line_end without de must not rekey.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 5)) step();
      rekey_line("rekey");
      wait_state(ST_REKEY_WAIT, 20, "rekey_wait");
      wait_state(ST_READY, 100, "rekey_back_ready");
    end
    line_end = 1'b1;
    step();
    line_end = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (cipher_rekey) cnt++;
      step();
    end
    check("no_rekey_without_de", 32'(cnt), 32'd0);

    // Nine frames with random mode/code; the counter must wrap once.
    r0 = n_ri;
    exp_enc = enc_active;
    for (int f = 0; f < 9; f++) begin
      e = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: c = CTL_ENC_EN;
        1: c = CTL_ENC_DIS;
        default: c = 4'b0101;
      endcase
      run_frame(e, c, "frame");
      if (!e) exp_enc = 1'b1;
      else if (c == CTL_ENC_EN) exp_enc = 1'b1;
      else if (c == CTL_ENC_DIS) exp_enc = 1'b0;
      exp_fc = (exp_fc + 1) % (1 << FCW);
      if (exp_fc == 0) exp_ri++;
      check("frame_fcnt", 32'(frame_cnt), 32'(exp_fc));
      check("frame_enc", 32'(enc_active), 32'(exp_enc));
    end
    step();
    check("ri_pulses", 32'(n_ri - r0), 32'(exp_ri));

    // Rekey in flight flushed by aksv_write; the cipher then never answers.
    de = 1'b1;
    line_end = 1'b1;
    step();
    de = 1'b0;
    line_end = 1'b0;
    cm_stuck = 1'b1;
    pulse_aksv();
    check("flush_rekey", 32'(cipher_rekey), 32'd0);
    check("reauth_pulse", 32'(state), 32'(ST_AUTH_PULSE));
    step();
    check("to_auth_wait", 32'(state), 32'(ST_AUTH_WAIT));
    cnt = 0;
    while (state == ST_AUTH_WAIT && cnt < 200) begin
      step();
      cnt++;
    end
    check("to_error", 32'(state), 32'(ST_ERROR));
    check("to_cycles", 32'(cnt), 32'(TMO));
    check("to_flag", 32'(timeout_err), 32'd1);
    repeat (10) step();
    check("error_holds", 32'(state), 32'(ST_ERROR));
    check("error_outs", 32'({cipher_init, cipher_auth, cipher_rekey, cipher_stream_ena}), 32'd0);

    // Recovery through a fresh authentication.
    cm_stuck = 1'b0;
    pulse_aksv();
    check("recover_pulse", 32'(state), 32'(ST_AUTH_PULSE));
    step();
    check("recover_to_clr", 32'(timeout_err), 32'd0);
    check("recover_fcnt", 32'(frame_cnt), 32'd0);
    wait_state(ST_FRAME_WAIT, 100, "recover_frame_wait");
    wait_state(ST_READY, 100, "recover_ready");

    // OESS frame, then hpd with aksv_write in the middle of a rekey handshake.
    run_frame(1'b0, 4'd0, "oess");
    check("oess_enc", 32'(enc_active), 32'd1);
    check("oess_fcnt", 32'(frame_cnt), 32'd1);
    rekey_line("rekey2");
    wait_state(ST_REKEY_WAIT, 20, "rekey2_wait");
    hpd = 1'b1;
    pulse_aksv();
    check("hpd_unplug", 32'(state), 32'(ST_UNPLUG));
    check("hpd_outs", 32'({cipher_init, cipher_auth, cipher_rekey, cipher_stream_ena,
                           enc_active, ri_update, timeout_err}), 32'd0);
    check("hpd_fcnt", 32'(frame_cnt), 32'd0);
    hpd = 1'b0;
    step();
    check("replug", 32'(state), 32'(ST_WAIT_AKSV));
    check("auth_only_with_init", 32'(n_auth_alone), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
